// File: rtl/instruction_cache_if.sv
// rtl/instruction_cache_if.sv - fetcher and memory-controller signal bundle for the instruction cache
interface instruction_cache_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  IFIC_en;
   logic [ADDR_WIDTH-1:0] IFIC_addr;
   logic                  ICIF_en;
   logic [31:0]           ICIF_data;
   logic                  ICMC_en;
   logic [ADDR_WIDTH-1:0] ICMC_addr;
   logic                  MCIC_en;
   logic [31:0]           MCIC_data;

   modport slave (
      input  IFIC_en, IFIC_addr, MCIC_en, MCIC_data,
      output ICIF_en, ICIF_data, ICMC_en, ICMC_addr
   );

   modport master (
      output IFIC_en, IFIC_addr, MCIC_en, MCIC_data,
      input  ICIF_en, ICIF_data, ICMC_en, ICMC_addr
   );
endinterface

// File: rtl/instruction_cache.sv
// rtl/instruction_cache.sv - direct-mapped read-only instruction cache with word-serial line fill
module instruction_cache #(
   parameter int ADDR_WIDTH  = 32,
   parameter int INDEX_WIDTH = 6,
   parameter int BLOCK_WIDTH = 2
) (
   input  logic               Sys_clk,
   input  logic               Sys_rst_n,
   input  logic               Sys_rdy,
   instruction_cache_if.slave bus
);
   localparam int OFFSET     = BLOCK_WIDTH + 2;
   localparam int TAG_WIDTH  = ADDR_WIDTH - OFFSET - INDEX_WIDTH;
   localparam int LINES      = 1 << INDEX_WIDTH;
   localparam int WORDS      = 1 << BLOCK_WIDTH;
   localparam int LINE_WIDTH = WORDS * 32;
   localparam logic [BLOCK_WIDTH-1:0] LAST_WORD = '1;

   typedef enum logic {IDLE, MISS} state_t;

   state_t                  state;
   state_t                  state_next;
   logic [LINES-1:0]        valid;
   logic [TAG_WIDTH-1:0]    tag_mem  [LINES];
   logic [LINE_WIDTH-1:0]   data_mem [LINES];
   logic [LINE_WIDTH-1:0]   fill_buf;
   logic [LINE_WIDTH-1:0]   fill_line;
   logic [BLOCK_WIDTH-1:0]  counter;
   logic [ADDR_WIDTH-1:0]   miss_addr;

   logic [INDEX_WIDTH-1:0]  req_index;
   logic [INDEX_WIDTH-1:0]  miss_index;
   logic [TAG_WIDTH-1:0]    req_tag;
   logic [TAG_WIDTH-1:0]    miss_tag;
   logic [BLOCK_WIDTH-1:0]  req_word;
   logic [BLOCK_WIDTH-1:0]  miss_word;
   logic                    req_take;
   logic                    hit;
   logic                    last_beat;

   logic                    icif_en_next;
   logic [31:0]             icif_data_next;
   logic                    icmc_en_next;
   logic [ADDR_WIDTH-1:0]   icmc_addr_next;
   logic                    start_fill;
   logic                    fill_beat;
   logic                    line_write;

   assign req_index  = bus.IFIC_addr[OFFSET+INDEX_WIDTH-1:OFFSET];
   assign req_tag    = bus.IFIC_addr[ADDR_WIDTH-1:OFFSET+INDEX_WIDTH];
   assign req_word   = bus.IFIC_addr[OFFSET-1:2];
   assign miss_index = miss_addr[OFFSET+INDEX_WIDTH-1:OFFSET];
   assign miss_tag   = miss_addr[ADDR_WIDTH-1:OFFSET+INDEX_WIDTH];
   assign miss_word  = miss_addr[OFFSET-1:2];

   // A response cycle blocks acceptance so a held request is not answered twice.
   assign req_take  = bus.IFIC_en && !bus.ICIF_en;
   assign hit       = valid[req_index] && (tag_mem[req_index] == req_tag);
   assign last_beat = bus.MCIC_en && (counter == LAST_WORD);

   // Completed line: buffered words plus the word arriving on the final beat.
   always_comb begin
      fill_line = fill_buf;
      fill_line[LINE_WIDTH-1 -: 32] = bus.MCIC_data;
   end

   always_ff @(posedge Sys_clk) begin
      if (!Sys_rst_n) begin
         state <= IDLE;
      end else if (Sys_rdy) begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req_take && !hit) state_next = MISS;
         MISS:    if (last_beat) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      icif_en_next   = 1'b0;
      icif_data_next = bus.ICIF_data;
      icmc_en_next   = bus.ICMC_en;
      icmc_addr_next = bus.ICMC_addr;
      start_fill     = 1'b0;
      fill_beat      = 1'b0;
      line_write     = 1'b0;
      case (state)
         IDLE: begin
            if (req_take) begin
               if (hit) begin
                  icif_en_next   = 1'b1;
                  icif_data_next = data_mem[req_index][{req_word, 5'd0} +: 32];
               end else begin
                  icmc_en_next   = 1'b1;
                  icmc_addr_next = {bus.IFIC_addr[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
                  start_fill     = 1'b1;
               end
            end
         end
         MISS: begin
            fill_beat = bus.MCIC_en;
            if (last_beat) begin
               line_write   = 1'b1;
               icmc_en_next = 1'b0;
               // Only answer if the fetcher still wants the missed address.
               if (bus.IFIC_en && (bus.IFIC_addr == miss_addr)) begin
                  icif_en_next   = 1'b1;
                  icif_data_next = fill_line[{miss_word, 5'd0} +: 32];
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge Sys_clk) begin
      if (!Sys_rst_n) begin
         valid         <= '0;
         counter       <= '0;
         miss_addr     <= '0;
         bus.ICIF_en   <= 1'b0;
         bus.ICIF_data <= '0;
         bus.ICMC_en   <= 1'b0;
         bus.ICMC_addr <= '0;
      end else if (Sys_rdy) begin
         bus.ICIF_en   <= icif_en_next;
         bus.ICIF_data <= icif_data_next;
         bus.ICMC_en   <= icmc_en_next;
         bus.ICMC_addr <= icmc_addr_next;
         if (start_fill) begin
            miss_addr <= bus.IFIC_addr;
            counter   <= '0;
         end else if (fill_beat) begin
            counter <= counter + BLOCK_WIDTH'(1);
         end
         if (line_write) begin
            valid[miss_index] <= 1'b1;
         end
      end
   end

   // Tag and data storage carry no reset; the valid bits alone gate their use.
   always_ff @(posedge Sys_clk) begin
      if (Sys_rst_n && Sys_rdy) begin
         if (fill_beat) begin
            fill_buf[{counter, 5'd0} +: 32] <= bus.MCIC_data;
         end
         if (line_write) begin
            tag_mem[miss_index]  <= miss_tag;
            data_mem[miss_index] <= fill_line;
         end
      end
   end
endmodule

// File: tb/tb_instruction_cache.sv
// tb/tb_instruction_cache.sv - scoreboard bench for instruction_cache against a transparent-memory model
module tb_instruction_cache;
   logic Sys_clk;
   logic Sys_rst_n;
   logic Sys_rdy;

   instruction_cache_if #(.ADDR_WIDTH(32)) bus ();

   instruction_cache #(
      .ADDR_WIDTH (32),
      .INDEX_WIDTH(6),
      .BLOCK_WIDTH(2)
   ) dut (
      .Sys_clk  (Sys_clk),
      .Sys_rst_n(Sys_rst_n),
      .Sys_rdy  (Sys_rdy),
      .bus      (bus)
   );

   initial begin
      Sys_clk = 1'b0;
      forever #5 Sys_clk = ~Sys_clk;
   end

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          resp_cyc = -5;
   int          fill_done_cyc = -1;
   int          words_done = 0;
   int          mem_idx = 0;
   bit          took = 1'b0;
   bit          rst_hit = 1'b0;
   logic [31:0] mem_ovr [logic [31:0]];
   bit          ref_valid [64];
   logic [21:0] ref_tag [64];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem_ovr.exists(a)) return mem_ovr[a];
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic bit model_hit(input logic [31:0] a);
      return ref_valid[a[9:4]] && (ref_tag[a[9:4]] == a[31:10]);
   endfunction

   task automatic model_fill(input logic [31:0] a);
      ref_valid[a[9:4]] = 1'b1;
      ref_tag[a[9:4]]   = a[31:10];
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   always @(posedge Sys_clk) begin
      cyc     <= cyc + 1;
      took    <= bus.MCIC_en && Sys_rdy && Sys_rst_n;
      rst_hit <= !Sys_rst_n;
      if (bus.MCIC_en && Sys_rdy && Sys_rst_n && mem_idx == 3) fill_done_cyc <= cyc + 1;
   end

   // Memory controller: serves a line word by word with random gaps, holding a word while frozen.
   initial begin
      bit          busy = 1'b0;
      int          gap = 0;
      logic [31:0] line = '0;
      bus.MCIC_en   = 1'b0;
      bus.MCIC_data = '0;
      forever begin
         @(negedge Sys_clk);
         if (rst_hit) begin
            busy        = 1'b0;
            bus.MCIC_en = 1'b0;
         end else begin
            if (busy && took) begin
               mem_idx++;
               words_done++;
               bus.MCIC_en = 1'b0;
               gap = $urandom_range(0, 2);
               if (mem_idx == 4) busy = 1'b0;
            end
            if (!busy && bus.ICMC_en) begin
               busy       = 1'b1;
               line       = bus.ICMC_addr;
               mem_idx    = 0;
               words_done = 0;
               gap        = $urandom_range(0, 2);
            end
            if (busy && !bus.MCIC_en) begin
               if (gap > 0) gap--;
               else begin
                  bus.MCIC_en   = 1'b1;
                  bus.MCIC_data = mem_rd(line + 32'(mem_idx * 4));
               end
            end
         end
      end
   end

   always @(negedge Sys_clk) begin
      if (Sys_rst_n && bus.ICIF_en) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_response actual=0x%0h required=none", bus.ICIF_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp_data", bus.ICIF_data, e.data);
            chk("resp_cycle", 32'(cyc), 32'((e.cyc < 0) ? fill_done_cyc : e.cyc));
         end
         resp_cyc = cyc;
      end
   end

   task automatic step();
      @(negedge Sys_clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] a, input bit want_resp);
      bit hit;
      int acc;
      hit = model_hit(a);
      acc = (cyc == resp_cyc) ? cyc + 2 : cyc + 1;
      bus.IFIC_en   = 1'b1;
      bus.IFIC_addr = a;
      if (want_resp) sb.push_back('{mem_rd(a), hit ? acc : -1});
      while (cyc < acc) step();
      if (hit) chk("hit_no_fill_req", {31'd0, bus.ICMC_en}, 32'd0);
      else begin
         chk("miss_fill_req", {31'd0, bus.ICMC_en}, 32'd1);
         chk("miss_fill_addr", bus.ICMC_addr, a & ~32'hF);
      end
   endtask

   task automatic wait_done(input logic [31:0] a);
      int t = 0;
      while (sb.size() != 0 && t < 400) begin
         step();
         t++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL response_timeout actual=none required=addr 0x%0h", a);
         sb.delete();
      end
      chk("fill_req_idle_after_resp", {31'd0, bus.ICMC_en}, 32'd0);
      model_fill(a);
      bus.IFIC_en = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] a);
      issue(a, 1'b1);
      wait_done(a);
   endtask

   task automatic wait_words(input int n);
      int t = 0;
      while (words_done < n && t < 200) begin
         step();
         t++;
      end
      if (words_done < n) begin
         checks++;
         failures++;
         $display("FAIL fill_word_timeout actual=%0d required=%0d", words_done, n);
      end
   endtask

   initial begin
      int start;
      int t;
      Sys_rst_n     = 1'b0;
      Sys_rdy       = 1'b1;
      bus.IFIC_en   = 1'b0;
      bus.IFIC_addr = '0;
      for (int i = 0; i < 4; i++) begin
         mem_ovr[32'h0 + 32'(4 * i)]   = 32'h11 * 32'(i + 1);
         mem_ovr[32'h400 + 32'(4 * i)] = 32'hA0 + 32'(i);
      end
      repeat (3) step();
      chk("reset_icif_en", {31'd0, bus.ICIF_en}, 32'd0);
      chk("reset_icif_data", bus.ICIF_data, 32'd0);
      chk("reset_icmc_en", {31'd0, bus.ICMC_en}, 32'd0);
      chk("reset_icmc_addr", bus.ICMC_addr, 32'd0);
      Sys_rst_n = 1'b1;
      step();

      fetch(32'h0000);
      fetch(32'h0008);
      fetch(32'h0400);
      fetch(32'h0000);

      issue(32'h0010, 1'b0);
      wait_words(2);
      bus.IFIC_addr = 32'h0100;
      start = fill_done_cyc;
      t = 0;
      while (fill_done_cyc == start && t < 200) begin
         step();
         t++;
      end
      chk("redirect_no_resp", {31'd0, bus.ICIF_en}, 32'd0);
      chk("redirect_fill_drop", {31'd0, bus.ICMC_en}, 32'd0);
      model_fill(32'h0010);
      fetch(32'h0100);
      fetch(32'h0010);

      issue(32'h0200, 1'b1);
      wait_words(1);
      Sys_rdy = 1'b0;
      repeat (3) begin
         step();
         chk("stall_fill_req", {31'd0, bus.ICMC_en}, 32'd1);
         chk("stall_fill_addr", bus.ICMC_addr, 32'h200);
         chk("stall_no_resp", {31'd0, bus.ICIF_en}, 32'd0);
      end
      Sys_rdy = 1'b1;
      wait_done(32'h0200);
      for (int i = 1; i < 4; i++) fetch(32'h0200 + 32'(4 * i));

      issue(32'h0300, 1'b0);
      wait_words(1);
      Sys_rst_n   = 1'b0;
      bus.IFIC_en = 1'b0;
      step();
      Sys_rst_n = 1'b1;
      chk("rst_miss_icmc_en", {31'd0, bus.ICMC_en}, 32'd0);
      chk("rst_miss_icif_en", {31'd0, bus.ICIF_en}, 32'd0);
      chk("rst_miss_icif_data", bus.ICIF_data, 32'd0);
      for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
      fetch(32'h0000);

      for (int n = 0; n < 250; n++) begin
         logic [31:0] a;
         a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) |
             (32'($urandom_range(0, 3)) << 2);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
         fetch(a);
      end

      repeat (4) step();
      chk("final_scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end
endmodule
